// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: FSM states,
// Game_status codes, playfield object codes and a BCD helper.
package snake_pkg;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_DYING = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam logic [2:0] GS_START = 3'b001;
  localparam logic [2:0] GS_PLAY  = 3'b010;
  localparam logic [2:0] GS_END   = 3'b100;

  typedef enum logic [1:0] {
    OBJ_NONE = 2'd0,
    OBJ_HEAD = 2'd1,
    OBJ_BODY = 2'd2,
    OBJ_WALL = 2'd3
  } object_e;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/snake_game_sequencer_if.sv
// Bundle of the game-control signals between the snake controller
// side (master) and the sequencer (slave).
interface snake_game_sequencer_if;

  logic       key_start;
  logic       hit_wall;
  logic       hit_body;
  logic       body_add;
  logic [2:0] game_status;
  logic       flash;
  logic       move_tick;
  logic [7:0] score;

  modport master (
    output key_start, hit_wall, hit_body, body_add,
    input  game_status, flash, move_tick, score
  );

  modport slave (
    input  key_start, hit_wall, hit_body, body_add,
    output game_status, flash, move_tick, score
  );

endinterface

// File: rtl/snake_score_bcd.sv
// Saturating two-digit BCD score counter (00..99).
// clr has priority over inc.
module snake_score_bcd
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr)
      value_d = 8'h00;
    else if (inc)
      value_d = bcd_inc_sat(value_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value_q <= 8'h00;
    else
      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game flow: START/PLAY/DYING/END, move ticks, flash, score.
// SNAKE_SPEEDUP_EN shortens the move period per apple eaten.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int MOVE_DIV   = 12_500_000,
  parameter int FLASH_HALF = 12_500_000,
  parameter int FLASH_CNT  = 8,
  parameter int MIN_DIV    = 3_125_000,
  parameter int SPEED_STEP = 625_000
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic       Key_start,
  input  logic       Hit_wall_sig,
  input  logic       Hit_body_sig,
  input  logic       Body_add_sig,
  output logic [2:0] Game_status,
  output logic       Flash_sig,
  output logic       Move_tick,
  output logic [7:0] Score
);

  localparam int CW = $clog2(MOVE_DIV + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam int TW = $clog2(FLASH_CNT + 1);

  localparam logic [FW-1:0] HALF_M1 = FW'(FLASH_HALF - 1);
  localparam logic [TW-1:0] TOG_M1  = TW'(FLASH_CNT - 1);

  if (MOVE_DIV < 1 || FLASH_HALF < 1 || FLASH_CNT < 1 ||
      MIN_DIV < 1 || MIN_DIV > MOVE_DIV || SPEED_STEP < 0)
  begin : g_param_err
    $error("snake_game_sequencer: bad parameters");
  end

  logic [1:0]    state_q, state_d;
  logic          key_q, body_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_m1;
  logic [FW-1:0] half_q, half_d;
  logic [TW-1:0] tog_q, tog_d;
  logic          flash_q, flash_d;
  logic          tick_q, tick_d;

  logic key_rise, body_rise, hit;
  logic play_go, inc, wrap;

  assign key_rise  = Key_start & ~key_q;
  assign body_rise = Body_add_sig & ~body_q;
  assign hit       = Hit_wall_sig | Hit_body_sig;
  assign play_go   = (state_q == S_START) & key_rise;
  assign inc       = (state_q == S_PLAY) & body_rise;
  assign wrap      = (cnt_q == per_m1);

`ifdef SNAKE_SPEEDUP_EN
  logic [7:0]    apples_q, apples_d;
  logic [CW-1:0] per_q, per_d;

  function automatic logic [CW-1:0] calc_period(
    input logic [7:0] n
  );
    longint sub, rem;
    sub = longint'(SPEED_STEP) * longint'(n);
    rem = longint'(MOVE_DIV) - sub;
    if (rem <= longint'(MIN_DIV))
      return CW'(MIN_DIV);
    return CW'(rem);
  endfunction

  always_comb begin
    apples_d = apples_q;
    per_d    = per_q;
    if (play_go) begin
      apples_d = 8'd0;
      per_d    = CW'(MOVE_DIV);
    end else begin
      if (inc && apples_q != 8'hFF)
        apples_d = apples_q + 8'd1;
      // A new period is only adopted at a step boundary.
      if (state_q == S_PLAY && !hit && wrap)
        per_d = calc_period(apples_d);
    end
  end

  always_ff @(posedge Clk_50mhz or posedge Rst) begin
    if (Rst) begin
      apples_q <= 8'd0;
      per_q    <= CW'(MOVE_DIV);
    end else begin
      apples_q <= apples_d;
      per_q    <= per_d;
    end
  end

  assign per_m1 = per_q - 1'b1;
`else
  assign per_m1 = CW'(MOVE_DIV - 1);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tog_d   = tog_q;
    flash_d = 1'b1;
    tick_d  = 1'b0;
    unique case (state_q)
      S_START: begin
        if (key_rise) begin
          state_d = S_PLAY;
          cnt_d   = '0;
        end
      end
      S_PLAY: begin
        if (hit) begin
          state_d = S_DYING;
          cnt_d   = '0;
          half_d  = '0;
          tog_d   = '0;
          flash_d = 1'b0;
        end else begin
          cnt_d  = wrap ? '0 : cnt_q + 1'b1;
          tick_d = wrap;
        end
      end
      S_DYING: begin
        flash_d = flash_q;
        if (half_q == HALF_M1) begin
          half_d  = '0;
          tog_d   = tog_q + 1'b1;
          flash_d = ~flash_q;
          // Last toggle lands on END with the snake drawn.
          if (tog_q == TOG_M1) begin
            state_d = S_END;
            tog_d   = '0;
            flash_d = 1'b1;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_END: begin
        if (key_rise)
          state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge Clk_50mhz or posedge Rst) begin
    if (Rst) begin
      state_q <= S_START;
      key_q   <= 1'b0;
      body_q  <= 1'b0;
      cnt_q   <= '0;
      half_q  <= '0;
      tog_q   <= '0;
      flash_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= Key_start;
      body_q  <= Body_add_sig;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tog_q   <= tog_d;
      flash_q <= flash_d;
      tick_q  <= tick_d;
    end
  end

  snake_score_bcd u_score (
    .clk   (Clk_50mhz),
    .rst   (Rst),
    .clr   (play_go),
    .inc   (inc),
    .value (Score)
  );

  always_comb begin
    Game_status = GS_PLAY;
    unique case (state_q)
      S_START: Game_status = GS_START;
      S_END:   Game_status = GS_END;
      default: Game_status = GS_PLAY;
    endcase
  end

  assign Flash_sig = flash_q;
  assign Move_tick = tick_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer with small periods.
// Define SNAKE_SPEEDUP_EN to also exercise the speed-up path.
module tb_snake_game_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  snake_game_sequencer_if bus ();

  snake_game_sequencer #(
    .MOVE_DIV   (4),
    .FLASH_HALF (2),
    .FLASH_CNT  (4),
    .MIN_DIV    (2),
    .SPEED_STEP (1)
  ) dut (
    .Clk_50mhz    (clk),
    .Rst          (rst),
    .Key_start    (bus.key_start),
    .Hit_wall_sig (bus.hit_wall),
    .Hit_body_sig (bus.hit_body),
    .Body_add_sig (bus.body_add),
    .Game_status  (bus.game_status),
    .Flash_sig    (bus.flash),
    .Move_tick    (bus.move_tick),
    .Score        (bus.score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] bcd_of(input int n);
    int m;
    m = (n > 99) ? 99 : n;
    return 8'(((m / 10) << 4) | (m % 10));
  endfunction

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    bus.key_start = 1'b0;
    bus.hit_wall  = 1'b0;
    bus.hit_body  = 1'b0;
    bus.body_add  = 1'b0;
    repeat (3) step();

    chk("rst_status", 32'(bus.game_status), 32'h1);
    chk("rst_flash", 32'(bus.flash), 32'h1);
    chk("rst_tick", 32'(bus.move_tick), 32'h0);
    chk("rst_score", 32'(bus.score), 32'h00);
    rst = 1'b0;
    step();
    chk("idle_status", 32'(bus.game_status), 32'h1);

    // Held key: one entry into PLAY, ticks at 4, 8, 12 after it.
    bus.key_start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 10) bus.key_start = 1'b0;
      chk($sformatf("play_status_%0d", i),
          32'(bus.game_status), 32'h2);
      chk($sformatf("play_tick_%0d", i),
          32'(bus.move_tick),
          32'((i == 5 || i == 9) ? 1 : 0));
    end

    // Hit on the cycle a tick is due: tick is suppressed.
    bus.hit_wall = 1'b1;
    step();
    bus.hit_wall = 1'b0;
    chk("hit_tick", 32'(bus.move_tick), 32'h0);
    chk("hit_status", 32'(bus.game_status), 32'h2);
    chk("hit_flash0", 32'(bus.flash), 32'h0);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("die_flash_%0d", i), 32'(bus.flash),
          32'((i == 1 || i == 4 || i == 5) ? 0 : 1));
      chk($sformatf("die_tick_%0d", i),
          32'(bus.move_tick), 32'h0);
      chk($sformatf("die_status_%0d", i),
          32'(bus.game_status), 32'h2);
    end
    step();
    chk("end_status", 32'(bus.game_status), 32'h4);
    chk("end_flash", 32'(bus.flash), 32'h1);
    bus.hit_body = 1'b1;
    step();
    bus.hit_body = 1'b0;
    chk("end_hit_ignored", 32'(bus.game_status), 32'h4);

    bus.key_start = 1'b1;
    step();
    chk("restart_status", 32'(bus.game_status), 32'h1);
    bus.key_start = 1'b0;
    step();
    bus.key_start = 1'b1;
    step();
    bus.key_start = 1'b0;
    chk("play2_status", 32'(bus.game_status), 32'h2);
    chk("play2_score", 32'(bus.score), 32'h00);

    // 100 apples: BCD counting up to a sticky 99.
    for (int k = 1; k <= 100; k++) begin
      bus.body_add = 1'b1;
      step();
      chk($sformatf("score_%0d", k), 32'(bus.score),
          32'(bcd_of(k)));
      bus.body_add = 1'b0;
      step();
    end

    bus.hit_wall = 1'b1;
    step();
    bus.hit_wall = 1'b0;
    repeat (8) step();
    chk("end2_status", 32'(bus.game_status), 32'h4);
    chk("end2_score", 32'(bus.score), 32'h99);
    bus.key_start = 1'b1;
    step();
    chk("start_score_hold", 32'(bus.score), 32'h99);
    bus.key_start = 1'b0;
    step();
    bus.key_start = 1'b1;
    step();
    bus.key_start = 1'b0;
    chk("play3_score_clr", 32'(bus.score), 32'h00);
    for (int k = 1; k <= 8; k++) begin
      bus.body_add = 1'b1;
      step();
      bus.body_add = 1'b0;
      step();
    end
    chk("score_08", 32'(bus.score), 32'h08);

    // Apple and body hit together: score counts, snake dies.
    bus.body_add = 1'b1;
    bus.hit_body = 1'b1;
    step();
    bus.body_add = 1'b0;
    bus.hit_body = 1'b0;
    chk("both_score", 32'(bus.score), 32'h09);
    chk("both_status", 32'(bus.game_status), 32'h2);
    chk("both_flash", 32'(bus.flash), 32'h0);
    chk("both_tick", 32'(bus.move_tick), 32'h0);
    step();
    step();
    chk("both_flash_tog", 32'(bus.flash), 32'h1);

    // Asynchronous reset in the middle of DYING.
    rst = 1'b1;
    #1;
    chk("arst_status", 32'(bus.game_status), 32'h1);
    chk("arst_flash", 32'(bus.flash), 32'h1);
    chk("arst_score", 32'(bus.score), 32'h00);
    chk("arst_tick", 32'(bus.move_tick), 32'h0);
    step();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("post_rst_tick_%0d", i),
          32'(bus.move_tick), 32'h0);
      chk($sformatf("post_rst_status_%0d", i),
          32'(bus.game_status), 32'h1);
      chk($sformatf("post_rst_flash_%0d", i),
          32'(bus.flash), 32'h1);
    end

`ifdef SNAKE_SPEEDUP_EN
    // Apples mid-step: spacing 4,3,2,2 (ticks at 4,7,9,11,13).
    bus.key_start = 1'b1;
    step();
    bus.key_start = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      step();
      chk($sformatf("speed_tick_%0d", j), 32'(bus.move_tick),
          32'((j == 4 || j == 7 || j == 9 ||
               j == 11 || j == 13) ? 1 : 0));
      bus.body_add = (j == 1 || j == 5 || j == 7);
    end
    bus.body_add = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
